// File: rtl/sd_cmd.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7 and captures the 48/136-bit response.
// Optional macro SD_CMD_NCC_EN adds an 8-SD-clock NCC gap (busy held, line released) after each transaction.
module sd_cmd #(
    parameter int TIMEOUT_CLOCKS = 64,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sd_clk_rising,
    input  logic        i_sd_clk_falling,
    output logic        o_sd_cmd_oe,
    output logic        o_sd_cmd_out,
    input  logic        i_sd_cmd_in,
    input  logic [5:0]  i_command_index,
    input  logic [31:0] i_command_argument,
    input  logic        i_command_long_response,
    input  logic        i_command_skip_response,
    input  logic        i_command_start,
    output logic [5:0]  o_command_index,
    output logic [31:0] o_command_response,
    output logic        o_command_busy,
    output logic        o_command_timeout,
    output logic        o_command_response_crc_error,
    output logic [2:0]  o_state
);

    // Handshake: i_command_start is accepted only while o_command_busy is low (IDLE).
    // Busy rises the cycle after acceptance and falls on the cycle the engine re-enters
    // IDLE; index/response/timeout/crc_error are stable from that cycle onward.

`ifdef SD_CMD_NCC_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_TX = 3'd1, S_WAIT = 3'd2, S_RX = 3'd3, S_NCC = 3'd4} state_t;
    localparam state_t S_DONE = S_NCC;
    localparam logic [CNT_W-1:0] NCC_LAST = CNT_W'(7);
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_TX = 3'd1, S_WAIT = 3'd2, S_RX = 3'd3} state_t;
    localparam state_t S_DONE = S_IDLE;
`endif

    localparam logic [CNT_W-1:0] TX_DATA_BITS = CNT_W'(40);
    localparam logic [CNT_W-1:0] TX_END_BIT   = CNT_W'(47);
    localparam logic [CNT_W-1:0] RX_LEN_SHORT = CNT_W'(48);
    localparam logic [CNT_W-1:0] RX_LEN_LONG  = CNT_W'(136);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT_CLOCKS);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [39:0]      tx_frame;
    logic [6:0]       crc;
    logic [45:0]      rx_shift;
    logic             long_r, skip_r;

    logic [CNT_W-1:0] cnt_inc, rx_len, crc_lo, crc_hi;
    logic             crc_in_win, crc_cmp_win, rx_last;
    logic [45:0]      rx_shift_next;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_next;
    end

    // Received bit positions are 1-based from the start bit; the CRC window skips the
    // 8-bit header of long responses and the compare window covers the 7 CRC bits.
    always_comb begin
        state_next    = state;
        cnt_inc       = cnt + 1'b1;
        rx_len        = long_r ? RX_LEN_LONG : RX_LEN_SHORT;
        crc_lo        = long_r ? CNT_W'(9) : CNT_W'(1);
        crc_hi        = rx_len - CNT_W'(8);
        crc_in_win    = (cnt_inc >= crc_lo) && (cnt_inc <= crc_hi);
        crc_cmp_win   = (cnt_inc > crc_hi) && (cnt_inc < rx_len);
        rx_last       = (cnt_inc == rx_len);
        rx_shift_next = {rx_shift[44:0], i_sd_cmd_in};
        case (state)
            S_IDLE: if (i_command_start) state_next = S_TX;
            S_TX: begin
                if (i_sd_clk_falling && cnt > TX_END_BIT)
                    state_next = skip_r ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (i_sd_clk_rising) begin
                    if (!i_sd_cmd_in)                state_next = S_RX;
                    else if (cnt_inc == TIMEOUT_CNT) state_next = S_DONE;
                end
            end
            S_RX: if (i_sd_clk_rising && rx_last) state_next = S_DONE;
`ifdef SD_CMD_NCC_EN
            S_NCC: if (i_sd_clk_rising && cnt == NCC_LAST) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt                          <= '0;
            tx_frame                     <= '0;
            crc                          <= '0;
            rx_shift                     <= '0;
            long_r                       <= 1'b0;
            skip_r                       <= 1'b0;
            o_sd_cmd_oe                  <= 1'b0;
            o_sd_cmd_out                 <= 1'b1;
            o_command_index              <= '0;
            o_command_response           <= '0;
            o_command_timeout            <= 1'b0;
            o_command_response_crc_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_command_start) begin
                        tx_frame                     <= {2'b01, i_command_index, i_command_argument};
                        long_r                       <= i_command_long_response;
                        skip_r                       <= i_command_skip_response;
                        crc                          <= '0;
                        cnt                          <= '0;
                        o_command_timeout            <= 1'b0;
                        o_command_response_crc_error <= 1'b0;
                    end
                end
                S_TX: begin
                    if (i_sd_clk_falling) begin
                        cnt         <= cnt_inc;
                        o_sd_cmd_oe <= 1'b1;
                        if (cnt < TX_DATA_BITS) begin
                            o_sd_cmd_out <= tx_frame[39];
                            tx_frame     <= {tx_frame[38:0], 1'b0};
                            crc          <= crc7_next(crc, tx_frame[39]);
                        end else if (cnt < TX_END_BIT) begin
                            o_sd_cmd_out <= crc[6];
                            crc          <= {crc[5:0], 1'b0};
                        end else if (cnt == TX_END_BIT) begin
                            o_sd_cmd_out <= 1'b1;
                        end else begin
                            o_sd_cmd_oe  <= 1'b0;
                            o_sd_cmd_out <= 1'b1;
                            cnt          <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_sd_clk_rising) begin
                        if (!i_sd_cmd_in) begin
                            // The start bit is response bit 1; a zero leaves the CRC at its init value.
                            cnt      <= CNT_W'(1);
                            crc      <= '0;
                            rx_shift <= {rx_shift[44:0], 1'b0};
                        end else if (cnt_inc == TIMEOUT_CNT) begin
                            o_command_timeout <= 1'b1;
                            cnt               <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_RX: begin
                    if (i_sd_clk_rising) begin
                        cnt      <= cnt_inc;
                        rx_shift <= rx_shift_next;
                        if (crc_in_win) begin
                            crc <= crc7_next(crc, i_sd_cmd_in);
                        end else if (crc_cmp_win) begin
                            if (i_sd_cmd_in != crc[6]) o_command_response_crc_error <= 1'b1;
                            crc <= {crc[5:0], 1'b0};
                        end
                        if (rx_last) begin
                            cnt                <= '0;
                            o_command_index    <= long_r ? 6'h3F : rx_shift_next[45:40];
                            o_command_response <= rx_shift_next[39:8];
                        end
                    end
                end
`ifdef SD_CMD_NCC_EN
                S_NCC: if (i_sd_clk_rising) cnt <= cnt_inc;
`endif
                default: cnt <= '0;
            endcase
        end
    end

    assign o_command_busy = (state != S_IDLE);
    assign o_state        = state;

endmodule

// File: tb/tb_sd_cmd.sv
// Scoreboard bench for sd_cmd: an SD bus/card model drives strobes and replies, a monitor
// checks each completed transaction against a CRC-by-polynomial-division reference model.
`timescale 1ns/1ps
module tb_sd_cmd;

    localparam int TO = 64;
`ifdef SD_CMD_NCC_EN
    localparam int NCC = 8;
`else
    localparam int NCC = 0;
`endif

    typedef struct packed {
        logic [47:0] tx;
        logic        to;
        logic        crc;
        logic [5:0]  idx;
        logic [31:0] resp;
        logic        chk;
        logic [15:0] rise;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sd_rise = 1'b0, sd_fall = 1'b0, sd_cmd_in = 1'b1;
    logic        cmd_oe, cmd_out;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_long = 1'b0, cmd_skip = 1'b0, cmd_start = 1'b0;
    logic [5:0]  rsp_idx;
    logic [31:0] rsp_word;
    logic        busy, timeout, crc_err;
    logic [2:0]  dbg_state;

    sd_cmd #(.TIMEOUT_CLOCKS(TO), .CNT_W(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_sd_clk_rising(sd_rise), .i_sd_clk_falling(sd_fall),
        .o_sd_cmd_oe(cmd_oe), .o_sd_cmd_out(cmd_out), .i_sd_cmd_in(sd_cmd_in),
        .i_command_index(cmd_idx), .i_command_argument(cmd_arg),
        .i_command_long_response(cmd_long), .i_command_skip_response(cmd_skip),
        .i_command_start(cmd_start),
        .o_command_index(rsp_idx), .o_command_response(rsp_word),
        .o_command_busy(busy), .o_command_timeout(timeout),
        .o_command_response_crc_error(crc_err), .o_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got hang required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    int          n_vec = 0, n_bad = 0;
    logic [5:0]  mdl_index = '0;
    logic [31:0] mdl_resp  = '0;

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int nbits);
        logic [134:0] work;
        work = {msg, 7'b0};
        for (int i = nbits + 6; i >= 7; i--)
            if (work[i]) work[i -: 8] = work[i -: 8] ^ 8'h89;
        return work[6:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SD bus + card model ----------------
    bit          card_q[$];
    int          card_wait = 0, card_sent = 0, tx_cnt = 0, rise_cnt = 0;
    bit          listen = 0;
    logic [47:0] tx_cap = '0;
    int          hp = 2, div_cnt = 0;
    bit          sd_level = 0;

    always @(negedge clk) begin
        // strobes presented at the last posedge have now been consumed by the DUT
        if (sd_fall) begin
            if (cmd_oe) begin
                tx_cap = {tx_cap[46:0], cmd_out};
                tx_cnt++;
            end else if (tx_cnt == 48 && !listen) begin
                listen = 1;
            end
            if (listen) begin
                if (card_wait > 0) card_wait--;
                else if (card_q.size() > 0) begin
                    sd_cmd_in = card_q.pop_front();
                    card_sent++;
                end else sd_cmd_in = 1'b1;
            end
        end
        sd_rise = 1'b0;
        sd_fall = 1'b0;
        if (div_cnt >= hp - 1) begin
            div_cnt  = 0;
            sd_level = !sd_level;
            if (sd_level) sd_rise = 1'b1;
            else          sd_fall = 1'b1;
        end else div_cnt++;
        if (sd_rise && listen) rise_cnt++;
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got busy fall required none");
                end else begin
                    e = exp_q.pop_front();
                    check("tx_frame", 64'(tx_cap), 64'(e.tx));
                    check("timeout", 64'(timeout), 64'(e.to));
                    check("crc_error", 64'(crc_err), 64'(e.crc));
                    check("resp_index", 64'(rsp_idx), 64'(e.idx));
                    check("resp_word", 64'(rsp_word), 64'(e.resp));
                    check("pad_oe_idle", 64'(cmd_oe), 64'(0));
                    check("pad_out_idle", 64'(cmd_out), 64'(1));
                    if (e.chk) check("sd_clocks_to_done", 64'(rise_cnt), 64'(e.rise));
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver ----------------
    task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg, input bit lng, input bit skp);
        cmd_idx = idx; cmd_arg = arg; cmd_long = lng; cmd_skip = skp; cmd_start = 1'b1;
        @(posedge clk); #2;
        cmd_start = 1'b0;
        // scramble the inputs so any use of unlatched values shows up
        cmd_idx = 6'($urandom); cmd_arg = $urandom; cmd_long = 1'($urandom); cmd_skip = 1'($urandom);
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit lng, input bit skp,
                           input bit ren, input logic [135:0] reply, input int dly,
                           input bit mid_start, input int abort_bit);
        exp_t       e;
        int         len, guard;
        logic [6:0] c;
        len   = lng ? 136 : 48;
        e.tx  = {2'b01, idx, arg, crc7_div(128'({2'b01, idx, arg}), 40), 1'b1};
        e.to  = 1'b0;
        e.crc = 1'b0;
        e.chk = 1'b1;
        if (skp) e.rise = 16'(NCC);
        else if (!ren) begin
            e.to   = 1'b1;
            e.rise = 16'(TO + NCC);
        end else begin
            e.rise = 16'(dly + len + NCC);
            if (lng) begin
                c = crc7_div(128'(reply[127:8]), 120);
                mdl_index = 6'h3F;
            end else begin
                c = crc7_div(128'(reply[47:8]), 40);
                mdl_index = reply[45:40];
            end
            e.crc    = (c != reply[7:1]);
            mdl_resp = reply[39:8];
        end
        if (abort_bit > 0) begin
            mdl_index = '0; mdl_resp = '0;
            e.chk = 1'b0; e.crc = 1'b0; e.to = 1'b0;
        end
        e.idx  = mdl_index;
        e.resp = mdl_resp;
        exp_q.push_back(e);

        @(posedge clk); #2;
        card_q.delete();
        if (ren && !skp) for (int i = len - 1; i >= 0; i--) card_q.push_back(reply[i]);
        card_wait = dly; card_sent = 0; listen = 0; tx_cnt = 0; rise_cnt = 0; sd_cmd_in = 1'b1;
        hp = $urandom_range(1, 2);
        pulse_start(idx, arg, lng, skp);

        if (mid_start) begin
            guard = 0;
            while (tx_cnt < 10 && guard < 5000) begin @(posedge clk); guard++; end
            #2;
            if (tx_cnt < 10) begin
                n_vec++; n_bad++;
                $display("FAIL mid_tx_wait: got %0d tx bits required 10", tx_cnt);
            end
            pulse_start(idx ^ 6'h15, ~arg, ~lng, 1'b1);
        end

        if (abort_bit > 0) begin
            guard = 0;
            while (card_sent < abort_bit && guard < 5000) begin @(posedge clk); guard++; end
            #3;
            rst_n = 1'b0;
            #1;
            check("rst_pad_oe", 64'(cmd_oe), 64'(0));
            check("rst_pad_out", 64'(cmd_out), 64'(1));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_index", 64'(rsp_idx), 64'(0));
            check("rst_resp", 64'(rsp_word), 64'(0));
            repeat (3) @(posedge clk);
            #2;
            card_q.delete(); listen = 0; sd_cmd_in = 1'b1;
            rst_n = 1'b1;
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin @(posedge clk); guard++; end
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: got busy still %0b required transaction end", busy);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [135:0] r8, rl;
        logic [119:0] pay;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_oe", 64'(cmd_oe), 64'(0));
        check("reset_out", 64'(cmd_out), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_timeout", 64'(timeout), 64'(0));
        check("reset_crc_error", 64'(crc_err), 64'(0));
        check("reset_index", 64'(rsp_idx), 64'(0));
        check("reset_resp", 64'(rsp_word), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        r8 = 136'h08000001AA13;
        run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 0);             // CMD0, no response
        run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b1, r8, 5, 1'b0, 0);          // CMD8 good reply
        run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b1, r8 ^ 136'h100000, 5, 1'b0, 0);
        run_cmd(6'd55, 32'h0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 0);           // CMD55 timeout
        pay = {$urandom, $urandom, $urandom, $urandom};
        rl  = {8'h3F, pay, crc7_div(128'(pay), 120), 1'b1};
        run_cmd(6'd2, 32'h0, 1'b1, 1'b0, 1'b1, rl, 3, 1'b1, 0);             // CMD2 + ignored start
        run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b1, r8, TO - 1, 1'b0, 0);     // start bit on last allowed clock
        run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b1, r8, 2, 1'b0, 20);         // reset during RX bit 20
        run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            logic [5:0]   idx;
            logic [31:0]  arg, rw;
            logic [135:0] rep;
            bit           lng, skp, ren;
            int           dly, k;
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            lng = ($urandom_range(0, 3) == 0);
            skp = ($urandom_range(0, 5) == 0);
            ren = ($urandom_range(0, 7) != 0);
            dly = $urandom_range(0, 10);
            if (lng) begin
                pay = {$urandom, $urandom, $urandom, $urandom};
                rep = {8'h3F, pay, crc7_div(128'(pay), 120), 1'b1};
                k   = $urandom_range(0, 127);
            end else begin
                rw  = $urandom;
                rep = 136'({2'b00, idx, rw, crc7_div(128'({2'b00, idx, rw}), 40), 1'b1});
                k   = $urandom_range(0, 45);
            end
            if ($urandom_range(0, 3) == 0) rep[k] = ~rep[k];
            run_cmd(idx, arg, lng, skp, ren, rep, dly, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
